// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, sequencer state encoding, instruction
// classes and the control-strobe bundle driven by control_sequencer.
package cpu_defs;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_NOP  = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11001;

  localparam logic [4:0] ALU_ADD = OP_ADD;

  typedef enum logic [3:0] {
    FETCH_T0,
    FETCH_T1,
    FETCH_T2,
    EXEC_T3,
    EXEC_T4,
    EXEC_T5,
    EXEC_T6,
    EXEC_T7,
    HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_REG,
    CLS_IMM,
    CLS_LD,
    CLS_ST,
    CLS_BR,
    CLS_JR,
    CLS_IN,
    CLS_OUT,
    CLS_NOP,
    CLS_HALT,
    CLS_BAD
  } instr_class_e;

  // Field order matches the concatenation of strobe ports in control_sequencer.
  typedef struct packed {
    logic pc_out;
    logic z_high_out;
    logic z_low_out;
    logic mdr_out;
    logic in_port_out;
    logic c_out;
    logic pc_in;
    logic ir_in;
    logic mar_in;
    logic mdr_in;
    logic y_in;
    logic z_in;
    logic out_port_in;
    logic con_in;
    logic inc_pc;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
    logic ba_out;
    logic read;
    logic write;
  } ctrl_t;

endpackage

// File: rtl/control_sequencer.sv
// Moore control sequencer for the datapath: fetch/execute state machine clocked
// on the falling edge so strobes are settled before the datapath's rising edge.
module control_sequencer
  import cpu_defs::*;
(
  input  logic        Clock,
  input  logic        clear_n,
  input  logic [31:0] ir,
  input  logic        branchCompare,
  input  logic        stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        InPortout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        Yin,
  output logic        Zin,
  output logic        OutPortin,
  output logic        CONin,
  output logic        IncPC,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        Read,
  output logic        Write,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal
);

  function automatic instr_class_e decode_class(input logic [4:0] op);
    instr_class_e cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: cls = CLS_REG;
      OP_ADDI, OP_ANDI, OP_ORI:      cls = CLS_IMM;
      OP_LD:                         cls = CLS_LD;
      OP_ST:                         cls = CLS_ST;
      OP_BR:                         cls = CLS_BR;
      OP_JR:                         cls = CLS_JR;
      OP_IN:                         cls = CLS_IN;
      OP_OUT:                        cls = CLS_OUT;
      OP_NOP:                        cls = CLS_NOP;
      OP_HALT:                       cls = CLS_HALT;
      default:                       cls = CLS_BAD;
    endcase
    return cls;
  endfunction

  state_e       state_q, state_d;
  logic         go_q, go_d;
  logic         last_state;
  logic [4:0]   opcode;
  instr_class_e cls;
  ctrl_t        ctrl;
  logic         unused_ir_bits;

  assign opcode         = ir[31:27];
  assign cls            = decode_class(opcode);
  assign unused_ir_bits = ^ir[26:0];

  // go_q holds off the first fetch until one falling edge after reset release.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d    = state_q;
    go_d       = 1'b1;
    last_state = 1'b0;
    if (!go_q) begin
      state_d = FETCH_T0;
    end else begin
      case (state_q)
        FETCH_T0: state_d = FETCH_T1;
        FETCH_T1: state_d = FETCH_T2;
        FETCH_T2: state_d = EXEC_T3;
        EXEC_T3: begin
          case (cls)
            CLS_REG, CLS_IMM, CLS_LD, CLS_ST, CLS_BR: state_d = EXEC_T4;
            CLS_HALT:                                 state_d = HALT;
            default:                                  last_state = 1'b1;
          endcase
        end
        EXEC_T4: state_d = EXEC_T5;
        EXEC_T5: begin
          if (cls inside {CLS_LD, CLS_ST, CLS_BR}) state_d = EXEC_T6;
          else                                     last_state = 1'b1;
        end
        EXEC_T6: begin
          if (cls inside {CLS_LD, CLS_ST}) state_d = EXEC_T7;
          else                             last_state = 1'b1;
        end
        EXEC_T7: last_state = 1'b1;
        HALT:    state_d = HALT;
        default: state_d = FETCH_T0;
      endcase
    end
    // stop is honoured only at an instruction boundary.
    if (last_state) state_d = stop ? HALT : FETCH_T0;
  end

  always_ff @(negedge Clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= FETCH_T0;
      go_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values together.
      state_q <= state_d;
      go_q    <= go_d;
    end
  end

  always_comb begin
    ctrl = '0;
    if (go_q) begin
      case (state_q)
        FETCH_T0: begin
          ctrl.pc_out = 1'b1; ctrl.mar_in = 1'b1; ctrl.inc_pc = 1'b1; ctrl.z_in = 1'b1;
        end
        FETCH_T1: begin
          ctrl.z_low_out = 1'b1; ctrl.pc_in = 1'b1; ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
        end
        FETCH_T2: begin
          ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1;
        end
        EXEC_T3: begin
          case (cls)
            CLS_REG, CLS_IMM: begin ctrl.grb = 1'b1; ctrl.r_out = 1'b1; ctrl.y_in = 1'b1; end
            CLS_LD, CLS_ST:   begin ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1; end
            CLS_BR:           begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.con_in = 1'b1; end
            CLS_JR:           begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.pc_in = 1'b1; end
            CLS_IN:           begin ctrl.in_port_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            CLS_OUT:          begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.out_port_in = 1'b1; end
            default:          ;
          endcase
        end
        EXEC_T4: begin
          case (cls)
            CLS_REG:                 begin ctrl.grc = 1'b1; ctrl.r_out = 1'b1; ctrl.z_in = 1'b1; end
            CLS_IMM, CLS_LD, CLS_ST: begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
            CLS_BR:                  begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
            default:                 ;
          endcase
        end
        EXEC_T5: begin
          case (cls)
            CLS_REG, CLS_IMM: begin ctrl.z_low_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            CLS_LD, CLS_ST:   begin ctrl.z_low_out = 1'b1; ctrl.mar_in = 1'b1; end
            CLS_BR:           begin ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; end
            default:          ;
          endcase
        end
        EXEC_T6: begin
          case (cls)
            CLS_LD: begin ctrl.read = 1'b1; ctrl.mdr_in = 1'b1; end
            CLS_ST: begin ctrl.gra = 1'b1; ctrl.r_out = 1'b1; ctrl.mdr_in = 1'b1; end
            CLS_BR: begin ctrl.z_low_out = 1'b1; ctrl.pc_in = branchCompare; end
            default: ;
          endcase
        end
        EXEC_T7: begin
          case (cls)
            CLS_LD:  begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.r_in = 1'b1; end
            CLS_ST:  ctrl.write = 1'b1;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Address arithmetic and PC increment always use ADD; other execute steps pass the opcode.
  always_comb begin
    alu_op = opcode;
    if (!go_q || state_q == HALT) begin
      alu_op = '0;
    end else if (state_q inside {FETCH_T0, FETCH_T1, FETCH_T2}) begin
      alu_op = ALU_ADD;
    end else if ((state_q == EXEC_T4 && cls inside {CLS_LD, CLS_ST}) ||
                 (state_q == EXEC_T5 && cls == CLS_BR)) begin
      alu_op = ALU_ADD;
    end
  end

  assign run     = (state_q != HALT);
  assign illegal = go_q && (state_q == EXEC_T3) && (cls == CLS_BAD);

  assign {PCout, Zhighout, Zlowout, MDRout, InPortout, Cout, PCin, IRin, MARin,
          MDRin, Yin, Zin, OutPortin, CONin, IncPC, Gra, Grb, Grc, Rin, Rout,
          BAout, Read, Write} = ctrl;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-state strobe/alu_op/run/illegal
// words are compared against hand-written expected sequences.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        clear_n;
  logic [31:0] ir;
  logic        branchCompare;
  logic        stop;
  logic PCout, Zhighout, Zlowout, MDRout, InPortout, Cout, PCin, IRin, MARin;
  logic MDRin, Yin, Zin, OutPortin, CONin, IncPC, Gra, Grb, Grc, Rin, Rout;
  logic BAout, Read, Write;
  logic [4:0] alu_op;
  logic       run, illegal;

  int n_compared   = 0;
  int n_mismatched = 0;
  int write_pulses = 0;
  logic [29:0] obs;

  localparam logic [22:0] M_PCOUT    = 23'h400000;
  localparam logic [22:0] M_ZLOWOUT  = 23'h100000;
  localparam logic [22:0] M_MDROUT   = 23'h080000;
  localparam logic [22:0] M_INPORT   = 23'h040000;
  localparam logic [22:0] M_COUT     = 23'h020000;
  localparam logic [22:0] M_PCIN     = 23'h010000;
  localparam logic [22:0] M_IRIN     = 23'h008000;
  localparam logic [22:0] M_MARIN    = 23'h004000;
  localparam logic [22:0] M_MDRIN    = 23'h002000;
  localparam logic [22:0] M_YIN      = 23'h001000;
  localparam logic [22:0] M_ZIN      = 23'h000800;
  localparam logic [22:0] M_OUTPORT  = 23'h000400;
  localparam logic [22:0] M_CONIN    = 23'h000200;
  localparam logic [22:0] M_INCPC    = 23'h000100;
  localparam logic [22:0] M_GRA      = 23'h000080;
  localparam logic [22:0] M_GRB      = 23'h000040;
  localparam logic [22:0] M_GRC      = 23'h000020;
  localparam logic [22:0] M_RIN      = 23'h000010;
  localparam logic [22:0] M_ROUT     = 23'h000008;
  localparam logic [22:0] M_BAOUT    = 23'h000004;
  localparam logic [22:0] M_READ     = 23'h000002;
  localparam logic [22:0] M_WRITE    = 23'h000001;

  localparam logic [22:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
  localparam logic [22:0] F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [22:0] F2 = M_MDROUT | M_IRIN;
  localparam logic [4:0]  A_ADD = 5'b00011;

  control_sequencer dut (
    .Clock(Clock), .clear_n(clear_n), .ir(ir), .branchCompare(branchCompare), .stop(stop),
    .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .InPortout(InPortout), .Cout(Cout), .PCin(PCin), .IRin(IRin), .MARin(MARin),
    .MDRin(MDRin), .Yin(Yin), .Zin(Zin), .OutPortin(OutPortin), .CONin(CONin),
    .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .Read(Read), .Write(Write), .alu_op(alu_op), .run(run),
    .illegal(illegal)
  );

  always #5 Clock = ~Clock;

  always @(posedge Write) write_pulses <= write_pulses + 1;

  function automatic logic [29:0] mk(input logic [22:0] s, input logic [4:0] a,
                                     input logic r, input logic il);
    return {s, a, r, il};
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  // Sample half a cycle after the sequencer's falling-edge update.
  task automatic sample();
    @(posedge Clock);
    #1;
    obs = {PCout, Zhighout, Zlowout, MDRout, InPortout, Cout, PCin, IRin, MARin,
           MDRin, Yin, Zin, OutPortin, CONin, IncPC, Gra, Grb, Grc, Rin, Rout,
           BAout, Read, Write, alu_op, run, illegal};
  endtask

  task automatic test_reset();
    clear_n = 1'b0; stop = 1'b0; branchCompare = 1'b0;
    ir = mk_ir(5'b11000, 4'd0, 4'd0, 19'd0);
    for (int i = 0; i < 2; i++) begin
      sample();
      n_compared++;
      if (obs !== mk(23'h0, 5'b0, 1'b1, 1'b0)) begin
        n_mismatched++;
        $display("FAIL reset_%0d: got %h expected %h", i, obs, mk(23'h0, 5'b0, 1'b1, 1'b0));
      end
    end
    #1 clear_n = 1'b1;
  endtask

  task automatic test_addi();
    logic [29:0] exp_w [6];
    exp_w[0] = mk(F0, A_ADD, 1'b1, 1'b0);
    exp_w[1] = mk(F1, A_ADD, 1'b1, 1'b0);
    exp_w[2] = mk(F2, A_ADD, 1'b1, 1'b0);
    exp_w[3] = mk(M_GRB | M_ROUT | M_YIN, 5'b01100, 1'b1, 1'b0);
    exp_w[4] = mk(M_COUT | M_ZIN, 5'b01100, 1'b1, 1'b0);
    exp_w[5] = mk(M_ZLOWOUT | M_GRA | M_RIN, 5'b01100, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i == 0) ir = mk_ir(5'b01100, 4'd3, 4'd4, 19'd15);
      n_compared++;
      if (obs !== exp_w[i]) begin
        n_mismatched++;
        $display("FAIL addi_T%0d: got %h expected %h", i, obs, exp_w[i]);
      end
    end
  endtask

  task automatic test_ld();
    logic [29:0] exp_w [8];
    exp_w[0] = mk(F0, A_ADD, 1'b1, 1'b0);
    exp_w[1] = mk(F1, A_ADD, 1'b1, 1'b0);
    exp_w[2] = mk(F2, A_ADD, 1'b1, 1'b0);
    exp_w[3] = mk(M_GRB | M_BAOUT | M_YIN, 5'b00000, 1'b1, 1'b0);
    exp_w[4] = mk(M_COUT | M_ZIN, A_ADD, 1'b1, 1'b0);
    exp_w[5] = mk(M_ZLOWOUT | M_MARIN, 5'b00000, 1'b1, 1'b0);
    exp_w[6] = mk(M_READ | M_MDRIN, 5'b00000, 1'b1, 1'b0);
    exp_w[7] = mk(M_MDROUT | M_GRA | M_RIN, 5'b00000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i == 0) ir = mk_ir(5'b00000, 4'd1, 4'd0, 19'h20);
      n_compared++;
      if (obs !== exp_w[i]) begin
        n_mismatched++;
        $display("FAIL ld_T%0d: got %h expected %h", i, obs, exp_w[i]);
      end
    end
  endtask

  task automatic test_st();
    logic [29:0] exp_w [8];
    exp_w[0] = mk(F0, A_ADD, 1'b1, 1'b0);
    exp_w[1] = mk(F1, A_ADD, 1'b1, 1'b0);
    exp_w[2] = mk(F2, A_ADD, 1'b1, 1'b0);
    exp_w[3] = mk(M_GRB | M_BAOUT | M_YIN, 5'b00010, 1'b1, 1'b0);
    exp_w[4] = mk(M_COUT | M_ZIN, A_ADD, 1'b1, 1'b0);
    exp_w[5] = mk(M_ZLOWOUT | M_MARIN, 5'b00010, 1'b1, 1'b0);
    exp_w[6] = mk(M_GRA | M_ROUT | M_MDRIN, 5'b00010, 1'b1, 1'b0);
    exp_w[7] = mk(M_WRITE, 5'b00010, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      sample();
      if (i == 0) ir = mk_ir(5'b00010, 4'd5, 4'd6, 19'h10);
      n_compared++;
      if (obs !== exp_w[i]) begin
        n_mismatched++;
        $display("FAIL st_T%0d: got %h expected %h", i, obs, exp_w[i]);
      end
    end
  endtask

  task automatic test_br(input logic bc);
    logic [29:0] exp_w [7];
    exp_w[0] = mk(F0, A_ADD, 1'b1, 1'b0);
    exp_w[1] = mk(F1, A_ADD, 1'b1, 1'b0);
    exp_w[2] = mk(F2, A_ADD, 1'b1, 1'b0);
    exp_w[3] = mk(M_GRA | M_ROUT | M_CONIN, 5'b10010, 1'b1, 1'b0);
    exp_w[4] = mk(M_PCOUT | M_YIN, 5'b10010, 1'b1, 1'b0);
    exp_w[5] = mk(M_COUT | M_ZIN, A_ADD, 1'b1, 1'b0);
    exp_w[6] = mk(M_ZLOWOUT | (bc ? M_PCIN : 23'h0), 5'b10010, 1'b1, 1'b0);
    branchCompare = bc;
    for (int i = 0; i < 7; i++) begin
      sample();
      if (i == 0) ir = mk_ir(5'b10010, 4'd2, 4'd0, 19'd3);
      n_compared++;
      if (obs !== exp_w[i]) begin
        n_mismatched++;
        $display("FAIL br%0d_T%0d: got %h expected %h", bc, i, obs, exp_w[i]);
      end
    end
  endtask

  // One-step instructions: jr, in, out, nop and an undefined opcode.
  task automatic test_short();
    logic [4:0]  ops   [5];
    logic [22:0] t3    [5];
    logic [29:0] exp_w [4];
    ops[0] = 5'b10100; t3[0] = M_GRA | M_ROUT | M_PCIN;
    ops[1] = 5'b10110; t3[1] = M_INPORT | M_GRA | M_RIN;
    ops[2] = 5'b10111; t3[2] = M_GRA | M_ROUT | M_OUTPORT;
    ops[3] = 5'b11000; t3[3] = 23'h0;
    ops[4] = 5'b11111; t3[4] = 23'h0;
    for (int k = 0; k < 5; k++) begin
      exp_w[0] = mk(F0, A_ADD, 1'b1, 1'b0);
      exp_w[1] = mk(F1, A_ADD, 1'b1, 1'b0);
      exp_w[2] = mk(F2, A_ADD, 1'b1, 1'b0);
      exp_w[3] = mk(t3[k], ops[k], 1'b1, (k == 4));
      for (int i = 0; i < 4; i++) begin
        sample();
        if (i == 0) ir = mk_ir(ops[k], 4'd7, 4'd0, 19'd0);
        n_compared++;
        if (obs !== exp_w[i]) begin
          n_mismatched++;
          $display("FAIL op%b_T%0d: got %h expected %h", ops[k], i, obs, exp_w[i]);
        end
      end
    end
  endtask

  task automatic reset_pulse(input string tag);
    clear_n = 1'b0;
    #1;
    n_compared++;
    if (obs !== obs || {PCout, Read, Write, MARin, Zin, IncPC, run, alu_op, illegal} !== 14'b000000_1_00000_0) begin
      n_mismatched++;
      $display("FAIL %s_async: got run=%b alu=%h strobes=%b%b%b%b%b%b ill=%b expected run=1 alu=0 strobes=0 ill=0",
               tag, run, alu_op, PCout, Read, Write, MARin, Zin, IncPC, illegal);
    end
    @(posedge Clock);
    #2 clear_n = 1'b1;
  endtask

  // stop raised mid add: the add completes, then the sequencer halts.
  task automatic test_stop();
    logic [29:0] exp_w [7];
    exp_w[0] = mk(F0, A_ADD, 1'b1, 1'b0);
    exp_w[1] = mk(F1, A_ADD, 1'b1, 1'b0);
    exp_w[2] = mk(F2, A_ADD, 1'b1, 1'b0);
    exp_w[3] = mk(M_GRB | M_ROUT | M_YIN, 5'b00011, 1'b1, 1'b0);
    exp_w[4] = mk(M_GRC | M_ROUT | M_ZIN, 5'b00011, 1'b1, 1'b0);
    exp_w[5] = mk(M_ZLOWOUT | M_GRA | M_RIN, 5'b00011, 1'b1, 1'b0);
    exp_w[6] = mk(23'h0, 5'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      sample();
      if (i == 0) ir = mk_ir(5'b00011, 4'd1, 4'd2, {4'd3, 15'd0});
      if (i == 3) stop = 1'b1;
      n_compared++;
      if (obs !== exp_w[i]) begin
        n_mismatched++;
        $display("FAIL stop_T%0d: got %h expected %h", i, obs, exp_w[i]);
      end
    end
    stop = 1'b0;
    reset_pulse("stop");
  endtask

  task automatic test_halt();
    logic [29:0] exp_w [4];
    exp_w[0] = mk(F0, A_ADD, 1'b1, 1'b0);
    exp_w[1] = mk(F1, A_ADD, 1'b1, 1'b0);
    exp_w[2] = mk(F2, A_ADD, 1'b1, 1'b0);
    exp_w[3] = mk(23'h0, 5'b11001, 1'b1, 1'b0);
    for (int i = 0; i < 24; i++) begin
      sample();
      if (i == 0) ir = mk_ir(5'b11001, 4'd0, 4'd0, 19'd0);
      n_compared++;
      if (obs !== ((i < 4) ? exp_w[i] : mk(23'h0, 5'b0, 1'b0, 1'b0))) begin
        n_mismatched++;
        $display("FAIL halt_%0d: got %h expected %h", i, obs,
                 (i < 4) ? exp_w[i] : mk(23'h0, 5'b0, 1'b0, 1'b0));
      end
    end
    reset_pulse("halt");
  endtask

  // Reset during st T6 must suppress the T7 write and restart at fetch.
  task automatic test_reset_mid_st();
    logic [29:0] exp_w [7];
    int          writes_before;
    writes_before = write_pulses;
    exp_w[0] = mk(F0, A_ADD, 1'b1, 1'b0);
    exp_w[1] = mk(F1, A_ADD, 1'b1, 1'b0);
    exp_w[2] = mk(F2, A_ADD, 1'b1, 1'b0);
    exp_w[3] = mk(M_GRB | M_BAOUT | M_YIN, 5'b00010, 1'b1, 1'b0);
    exp_w[4] = mk(M_COUT | M_ZIN, A_ADD, 1'b1, 1'b0);
    exp_w[5] = mk(M_ZLOWOUT | M_MARIN, 5'b00010, 1'b1, 1'b0);
    exp_w[6] = mk(M_GRA | M_ROUT | M_MDRIN, 5'b00010, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) begin
      sample();
      if (i == 0) ir = mk_ir(5'b00010, 4'd5, 4'd6, 19'h10);
      n_compared++;
      if (obs !== exp_w[i]) begin
        n_mismatched++;
        $display("FAIL rst_st_T%0d: got %h expected %h", i, obs, exp_w[i]);
      end
    end
    reset_pulse("rst_st");
    sample();
    n_compared++;
    if (obs !== mk(F0, A_ADD, 1'b1, 1'b0)) begin
      n_mismatched++;
      $display("FAIL rst_st_refetch: got %h expected %h", obs, mk(F0, A_ADD, 1'b1, 1'b0));
    end
    sample();
    n_compared++;
    if (write_pulses !== writes_before) begin
      n_mismatched++;
      $display("FAIL rst_st_write: got %0d write pulses expected 0", write_pulses - writes_before);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_ld();
    test_st();
    test_br(1'b1);
    test_br(1'b0);
    test_short();
    test_stop();
    test_halt();
    test_reset_mid_st();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no completion expected finish before 50000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have a single clock and an asynchronous active-low reset: Clock (in, 1) and clear_n (in, 1, asserted when low).
REQ-002 Clock  in  1  system clock shared with data_path.
REQ-003 clear_n  in  1  asynchronous active-low reset.
REQ-004 ir  in  32  instruction register contents (irOut); opcode = ir[31:27].
REQ-005 branchCompare  in  1  CON result from data_path.
REQ-006 stop  in  1  request halt at the next instruction boundary.
REQ-007 PCout, Zhighout, Zlowout, MDRout, InPortout, Cout  out  1 each  bus-source selects.
REQ-008 PCin, IRin, MARin, MDRin, Yin, Zin, OutPortin, CONin, IncPC  out  1 each  register loads.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout, Read, Write  out  1 each  register-select and memory strobes.
REQ-010 alu_op  out  5  ALU operation (opcode during execute; ADD during fetch and address calculation).
REQ-011 run  out  1  high while not halted.
REQ-012 illegal  out  1  one-cycle pulse when an undefined opcode is decoded.

Function
REQ-013 The state register SHALL update on the falling edge of Clock, so that outputs are stable before data_path captures on the rising edge.
REQ-014 Outputs SHALL be decoded purely from state (Moore), plus branchCompare gating in BR_T6 only.
REQ-015 States: FETCH_T0, FETCH_T1, FETCH_T2, EXEC_T3..EXEC_T7, HALT.
REQ-016 FETCH_T0 SHALL assert PCout, MARin, IncPC, Zin.
REQ-017 FETCH_T1 SHALL assert Zlowout, PCin, Read, MDRin.
REQ-018 FETCH_T2 SHALL assert MDRout, IRin; the next state is EXEC_T3.
REQ-019 Reg ALU (add 00011, sub 00100, and 00101, or 00110): T3 Grb,Rout,Yin; T4 Grc,Rout,Zin; T5 Zlowout,Gra,Rin; then FETCH_T0.
REQ-020 Imm ALU (addi 01100, andi 01101, ori 01110): T3 Grb,Rout,Yin; T4 Cout,Zin; T5 Zlowout,Gra,Rin; then FETCH_T0.
REQ-021 ld (00000): T3 Grb,BAout,Yin; T4 Cout,Zin (alu_op=ADD); T5 Zlowout,MARin; T6 Read,MDRin; T7 MDRout,Gra,Rin.
REQ-022 st (00010): T3-T5 as ld; T6 Gra,Rout,MDRin (Read low); T7 Write.
REQ-023 br (10010): T3 Gra,Rout,CONin; T4 PCout,Yin; T5 Cout,Zin (ADD); T6 Zlowout, with PCin asserted only if branchCompare=1.
REQ-024 jr (10100): T3 Gra,Rout,PCin.  in (10110): T3 InPortout,Gra,Rin.  out (10111): T3 Gra,Rout,OutPortin.
REQ-025 nop (11000) SHALL go from EXEC_T3 to FETCH_T0 with no strobes; halt (11001) SHALL go to HALT.
REQ-026 An undefined opcode SHALL behave as nop and pulse illegal during EXEC_T3.
REQ-027 stop sampled high at the last state of an instruction SHALL route to HALT instead of FETCH_T0; a mid-instruction stop SHALL NOT abort the instruction.
REQ-028 HALT SHALL assert no strobes and hold run=0 until reset.
REQ-029 At most one bus-source select SHALL be high in any state.

Reset
REQ-030 clear_n low SHALL immediately force FETCH_T0 with all strobes 0, alu_op=0, illegal=0, run=1 — including mid-instruction and from HALT.
REQ-031 Release of reset SHALL start a fetch on the first following falling edge.

Structure
REQ-032 The opcode constants, the state encoding, and the ALU_ADD code SHALL reside in the shared package cpu_defs.
REQ-033 The block SHALL be a single module with no sub-modules; the opcode decode SHALL be a function inside the module.

Verification
REQ-034 Reset, then ir=addi R3,R4,15 → T0-T5 sequence exactly as REQ-016..020; Rin with Gra in T5; back to FETCH_T0.
REQ-035 ld R1,0x20(R0) → BAout in T3, Read+MDRin in T6, MDRout+Gra+Rin in T7; 8 cycles in total.
REQ-036 br (brpl) with branchCompare=1 → PCin in T6; with branchCompare=0 → PCin low in T6.
REQ-037 opcode 11111 → illegal pulses once, no strobes, fetch resumes next cycle.
REQ-038 halt → run=0 and outputs remain 0 for 20 cycles; clear_n pulse low → FETCH_T0, run=1.
REQ-039 clear_n asserted in st EXEC_T6 → Write is never asserted, and state becomes FETCH_T0 asynchronously.
